// File: rtl/w_stage_reg.sv
// Memory-to-writeback pipeline register of the Y86-64 pipe, with the processor status FSM.
// Optional W_RETIRE_CNT_EN macro adds a 64-bit retired-instruction counter.
module w_stage_reg #(
   parameter logic [3:0] RNONE = 4'hF,
   parameter logic [3:0] INOP  = 4'h1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        W_bubble_req,
   input  logic        W_stall_req,
   input  logic [2:0]  m_stat,
   input  logic [3:0]  M_icode,
   input  logic [3:0]  M_dstE,
   input  logic [3:0]  M_dstM,
   input  logic [63:0] M_valE,
   input  logic [63:0] m_valM,
   output logic [2:0]  W_stat,
   output logic [3:0]  W_icode,
   output logic [3:0]  W_dstE,
   output logic [3:0]  W_dstM,
   output logic [63:0] W_valE,
   output logic [63:0] W_valM,
   output logic [3:0]  wb_dstE,
   output logic [3:0]  wb_dstM,
   output logic [2:0]  stat,
   output logic        halted,
   output logic [63:0] retire_cnt
);

   localparam logic [2:0] SBUB = 3'd0;
   localparam logic [2:0] SAOK = 3'd1;
   localparam logic [2:0] SHLT = 3'd2;
   localparam logic [2:0] SADR = 3'd3;
   localparam logic [2:0] SINS = 3'd4;

   typedef enum logic {
      RUN     = 1'b0,
      STOPPED = 1'b1
   } state_t;

   state_t state;
   logic   wExc;
   logic   freeze;
   logic   stallEff;
   logic   canWrite;

   // An exceptional entry freezes W so nothing younger ever lands behind it.
   assign wExc     = (W_stat == SHLT) || (W_stat == SADR) || (W_stat == SINS);
   assign freeze   = wExc || (state == STOPPED);
   assign stallEff = W_stall_req || freeze;
   assign canWrite = (state == RUN) && (W_stat == SAOK);

   assign wb_dstE = canWrite ? W_dstE : RNONE;
   assign wb_dstM = canWrite ? W_dstM : RNONE;

   always_ff @(posedge clk) begin
      if (reset) begin
         W_stat  <= SBUB;
         W_icode <= INOP;
         W_dstE  <= RNONE;
         W_dstM  <= RNONE;
         W_valE  <= 64'h0;
         W_valM  <= 64'h0;
         state   <= RUN;
         stat    <= SAOK;
         halted  <= 1'b0;
      end else begin
         if (!stallEff) begin
            if (W_bubble_req) begin
               W_stat  <= SBUB;
               W_icode <= INOP;
               W_dstE  <= RNONE;
               W_dstM  <= RNONE;
               W_valE  <= 64'h0;
               W_valM  <= 64'h0;
            end else begin
               W_stat  <= m_stat;
               W_icode <= M_icode;
               W_dstE  <= M_dstE;
               W_dstM  <= M_dstM;
               W_valE  <= M_valE;
               W_valM  <= m_valM;
            end
         end
         // First exception to reach W is captured and held until reset.
         case (state)
            RUN: begin
               if (wExc) begin
                  state  <= STOPPED;
                  stat   <= W_stat;
                  halted <= 1'b1;
               end else begin
                  stat <= (W_stat == SBUB) ? SAOK : W_stat;
               end
            end
            default: begin
               state  <= STOPPED;
               halted <= 1'b1;
            end
         endcase
      end
   end

`ifdef W_RETIRE_CNT_EN
   logic [63:0] retireCnt;

   // An SAOK entry retires on the edge where it leaves W.
   always_ff @(posedge clk) begin
      if (reset) begin
         retireCnt <= 64'h0;
      end else if (canWrite && !stallEff) begin
         retireCnt <= retireCnt + 64'd1;
      end
   end

   assign retire_cnt = retireCnt;
`else
   assign retire_cnt = 64'h0;
`endif

endmodule

// File: tb/tb_w_stage_reg.sv
// Randomized bench for w_stage_reg: behavioural model of W, status and retire count
// compared every cycle, plus directed literal checks.
module tb_w_stage_reg;

   logic        clk = 1'b0;
   logic        reset;
   logic        W_bubble_req, W_stall_req;
   logic [2:0]  m_stat;
   logic [3:0]  M_icode, M_dstE, M_dstM;
   logic [63:0] M_valE, m_valM;
   logic [2:0]  W_stat;
   logic [3:0]  W_icode, W_dstE, W_dstM, wb_dstE, wb_dstM;
   logic [63:0] W_valE, W_valM, retire_cnt;
   logic [2:0]  stat;
   logic        halted;

   int total = 0;
   int bad   = 0;
   bit checkOn = 1'b0;

   w_stage_reg dut (
      .clk(clk), .reset(reset),
      .W_bubble_req(W_bubble_req), .W_stall_req(W_stall_req),
      .m_stat(m_stat), .M_icode(M_icode), .M_dstE(M_dstE), .M_dstM(M_dstM),
      .M_valE(M_valE), .m_valM(m_valM),
      .W_stat(W_stat), .W_icode(W_icode), .W_dstE(W_dstE), .W_dstM(W_dstM),
      .W_valE(W_valE), .W_valM(W_valM),
      .wb_dstE(wb_dstE), .wb_dstM(wb_dstM),
      .stat(stat), .halted(halted), .retire_cnt(retire_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  st;
      logic [3:0]  ic, de, dm;
      logic [63:0] ve, vm;
   } entry_t;

   entry_t      mW;
   bit          mStop;
   logic [2:0]  mStat;
   logic [63:0] mRet;

   function automatic entry_t bubbleEntry();
      entry_t e;
      e.st = 3'd0; e.ic = 4'h1; e.de = 4'hF; e.dm = 4'hF; e.ve = 64'h0; e.vm = 64'h0;
      return e;
   endfunction

   // Reference model: what W, status and the counter must become on each edge.
   always @(posedge clk) begin
      if (reset) begin
         mW = bubbleEntry(); mStop = 1'b0; mStat = 3'd1; mRet = 64'h0;
      end else begin
         bit exc, hold;
         exc  = (mW.st == 3'd2) || (mW.st == 3'd3) || (mW.st == 3'd4);
         hold = W_stall_req || exc || mStop;
         if (!mStop && mW.st == 3'd1 && !hold) mRet = mRet + 64'd1;
         if (!mStop) begin
            if (exc) begin mStop = 1'b1; mStat = mW.st; end
            else mStat = (mW.st == 3'd0) ? 3'd1 : mW.st;
         end
         if (!hold) begin
            if (W_bubble_req) mW = bubbleEntry();
            else begin
               mW.st = m_stat; mW.ic = M_icode; mW.de = M_dstE; mW.dm = M_dstM;
               mW.ve = M_valE; mW.vm = m_valM;
            end
         end
      end
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Per-cycle comparison against the model, away from the active edge.
   always @(negedge clk) begin
      if (checkOn) begin
         bit wr;
         wr = !mStop && (mW.st == 3'd1);
         check("W_stat",  64'(W_stat),  64'(mW.st));
         check("W_icode", 64'(W_icode), 64'(mW.ic));
         check("W_dstE",  64'(W_dstE),  64'(mW.de));
         check("W_dstM",  64'(W_dstM),  64'(mW.dm));
         check("W_valE",  W_valE, mW.ve);
         check("W_valM",  W_valM, mW.vm);
         check("wb_dstE", 64'(wb_dstE), 64'(wr ? mW.de : 4'hF));
         check("wb_dstM", 64'(wb_dstM), 64'(wr ? mW.dm : 4'hF));
         check("stat",    64'(stat),    64'(mStat));
         check("halted",  64'(halted),  64'(mStop));
`ifdef W_RETIRE_CNT_EN
         check("retire_cnt", retire_cnt, mRet);
`else
         check("retire_cnt", retire_cnt, 64'h0);
`endif
      end
   end

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   task automatic setM(input logic [2:0] st, input logic [3:0] ic, input logic [3:0] de,
                       input logic [3:0] dm, input logic [63:0] ve, input logic [63:0] vm);
      m_stat = st; M_icode = ic; M_dstE = de; M_dstM = dm; M_valE = ve; m_valM = vm;
   endtask

   task automatic doReset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic checkResetState(input string tag);
      check({tag, "_W_stat"},  64'(W_stat),  64'h0);
      check({tag, "_W_icode"}, 64'(W_icode), 64'h1);
      check({tag, "_W_dstE"},  64'(W_dstE),  64'hF);
      check({tag, "_W_dstM"},  64'(W_dstM),  64'hF);
      check({tag, "_wb_dstE"}, 64'(wb_dstE), 64'hF);
      check({tag, "_wb_dstM"}, 64'(wb_dstM), 64'hF);
      check({tag, "_stat"},    64'(stat),    64'h1);
      check({tag, "_halted"},  64'(halted),  64'h0);
      check({tag, "_retire"},  retire_cnt,   64'h0);
   endtask

   initial begin
      reset = 1'b1; W_bubble_req = 1'b0; W_stall_req = 1'b0;
      setM(3'd0, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0);
      tick();
      tick();
      reset = 1'b0;
      checkOn = 1'b1;
      checkResetState("rst");

      // Plain SAOK instruction writes through to the register file.
      setM(3'd1, 4'h6, 4'h2, 4'hF, 64'h15, 64'h0);
      tick();
      check("op_W_dstE", 64'(W_dstE), 64'h2);
      check("op_wb_dstE", 64'(wb_dstE), 64'h2);
      check("op_W_valE", W_valE, 64'h15);
      setM(3'd0, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0);
      tick();
`ifdef W_RETIRE_CNT_EN
      check("op_retire", retire_cnt, 64'h1);
`endif

      // Stall beats bubble; W holds until the stall drops.
      setM(3'd1, 4'h5, 4'hF, 4'h3, 64'h0, 64'hDEAD);
      W_stall_req = 1'b1; W_bubble_req = 1'b1;
      tick();
      check("stall_W_stat", 64'(W_stat), 64'h0);
      check("stall_W_dstM", 64'(W_dstM), 64'hF);
      tick();
      check("stall2_W_dstM", 64'(W_dstM), 64'hF);
      W_stall_req = 1'b0; W_bubble_req = 1'b0;
      tick();
      check("unstall_W_dstM", 64'(W_dstM), 64'h3);
      check("unstall_wb_dstM", 64'(wb_dstM), 64'h3);
      check("unstall_W_valM", W_valM, 64'hDEAD);

      // SINS freezes the pipe and sticks.
      setM(3'd4, 4'hF, 4'h1, 4'hF, 64'h0, 64'h0);
      tick();
      check("sins_W_stat", 64'(W_stat), 64'h4);
      check("sins_wb_dstE", 64'(wb_dstE), 64'hF);
      check("sins_halted0", 64'(halted), 64'h0);
      setM(3'd1, 4'h6, 4'h7, 4'h8, 64'h99, 64'h77);
      tick();
      check("sins_halted", 64'(halted), 64'h1);
      check("sins_stat", 64'(stat), 64'h4);
      for (int i = 0; i < 10; i++) begin
         W_bubble_req = 1'($urandom_range(0, 1));
         setM(3'd1, 4'($urandom), 4'($urandom), 4'($urandom), 64'($urandom), 64'($urandom));
         tick();
         check("frozen_stat", 64'(stat), 64'h4);
         check("frozen_W_stat", 64'(W_stat), 64'h4);
      end
      W_bubble_req = 1'b0;

      // HLT then ADR: first exception wins, halting instruction not counted.
      doReset();
      setM(3'd2, 4'h0, 4'hF, 4'hF, 64'h0, 64'h0);
      tick();
      setM(3'd3, 4'h5, 4'h1, 4'h2, 64'h0, 64'h0);
      tick();
      tick();
      check("hlt_stat", 64'(stat), 64'h2);
      check("hlt_W_stat", 64'(W_stat), 64'h2);
      check("hlt_halted", 64'(halted), 64'h1);
      check("hlt_retire", retire_cnt, 64'h0);
      doReset();
      checkResetState("rst2");

`ifdef W_RETIRE_CNT_EN
      // Counter wraps from all-ones to zero.
      setM(3'd0, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0);
      tick();
      force dut.retireCnt = 64'hFFFF_FFFF_FFFF_FFFF;
      mRet = 64'hFFFF_FFFF_FFFF_FFFF;
      #1;
      release dut.retireCnt;
      setM(3'd1, 4'h6, 4'h4, 4'hF, 64'h1, 64'h0);
      tick();
      setM(3'd0, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0);
      tick();
      check("wrap_retire", retire_cnt, 64'h0);
`endif

      // Random episodes, each ending in reset.
      for (int ep = 0; ep < 30; ep++) begin
         doReset();
         for (int c = 0; c < 60; c++) begin
            int r;
            logic [2:0] s;
            r = $urandom_range(0, 99);
            if (r < 50)      s = 3'd1;
            else if (r < 88) s = 3'd0;
            else if (r < 92) s = 3'd2;
            else if (r < 96) s = 3'd3;
            else             s = 3'd4;
            W_stall_req  = ($urandom_range(0, 99) < 20);
            W_bubble_req = ($urandom_range(0, 99) < 15);
            setM(s, 4'($urandom), 4'($urandom), 4'($urandom),
                 {$urandom, $urandom}, {$urandom, $urandom});
            tick();
         end
      end
      W_stall_req = 1'b0; W_bubble_req = 1'b0;
      doReset();
      checkResetState("rst3");

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
